bcd_down_timer: RTL

- Programmable multi-digit BCD countdown timer; the down-counting counterpart of the decade up counter in the lab counter set.
- Loads a BCD preset, counts down one per enabled clock with digit-to-digit borrow, and stops at zero with a one-cycle done pulse.
- Used as a cycle/event timer feeding display and sequencing logic.

---
 rtl/counter_pkg.sv | 14 +
 rtl/bcd_down_digit.sv | 31 +++
 rtl/bcd_down_timer.sv | 93 +++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Constants shared by the BCD counter slice: digit width, digit limit and FSM encodings.
package counter_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    function automatic logic bcd_ok(input logic [BCD_W-1:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of a down counter. A borrow from below decrements it, and a digit at 0
// wraps to 9 and passes the borrow upward.
module bcd_down_digit
    import counter_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [BCD_W-1:0] din,
    input  logic             dec_en,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] q,
    output logic             borrow_out
);

    logic step;

    assign step       = dec_en && borrow_in;
    assign borrow_out = step && (q == '0);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (step) begin
            q <= (q == '0) ? BCD_MAX : q - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_down_timer.sv
// Programmable BCD countdown timer: validated preset load, IDLE/RUN control with pause,
// a one-cycle done pulse when the count reaches zero, and a sticky bad-preset flag.
module bcd_down_timer
    import counter_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  pause,
    output logic [4*DIGITS-1:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  tc,
    output logic                  err
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ONE = W'(1);

    logic [0:0]    state;
    logic          load_ok;
    logic          dig_load;
    logic          dec_en;
    logic          count_zero;
    logic [DIGITS:0] borrow;
    logic          unused_borrow;

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_ok(load_val[i*BCD_W +: BCD_W])) load_ok = 1'b0;
        end
    end

    assign count_zero = (count == '0);
    assign tc         = count_zero;
    assign busy       = (state == RUN);
    assign dig_load   = load && load_ok;
    // The zero guard keeps the chain from ever borrowing past 00.
    assign dec_en     = busy && !pause && !load && !count_zero;

    assign borrow[0]     = 1'b1;
    assign unused_borrow = borrow[DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_down_digit u_digit (
            .clk        (clk),
            .clr        (clr),
            .load       (dig_load),
            .din        (load_val[g*BCD_W +: BCD_W]),
            .dec_en     (dec_en),
            .borrow_in  (borrow[g]),
            .q          (count[g*BCD_W +: BCD_W]),
            .borrow_out (borrow[g+1])
        );
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                state <= IDLE;
                err   <= !load_ok;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            // A held start on a zero count must not produce back-to-back pulses.
                            if (count_zero) done <= !done;
                            else            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (!pause && count == ONE) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
